// File: rtl/hyper_ram_txn_scheduler_if.sv
// hyper_ram_txn_scheduler_if
// Bundles the client request channels, the per-channel completion pulses and the
// burst handshake towards the HyperRAM driver.
//   req_valid/ready/addr/len/rw : N_CH request channels, fields packed per channel
//   cmp_done/cmp_err            : per-channel completion / timeout-abort pulses
//   drv_start/ca/len/rw/done    : burst handshake with the driver
//   cur_ch/busy                 : status of the scheduler
// Modport slave is the scheduler's view; master is the client/driver side.
interface hyper_ram_txn_scheduler_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned LEN_W  = 11
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]        req_valid;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH*ADDR_W-1:0] req_addr;
    logic [N_CH*LEN_W-1:0]  req_len;
    logic [N_CH-1:0]        req_rw;
    logic [N_CH-1:0]        cmp_done;
    logic [N_CH-1:0]        cmp_err;
    logic                   drv_start;
    logic [47:0]            drv_ca;
    logic [LEN_W-1:0]       drv_len;
    logic                   drv_rw;
    logic                   drv_done;
    logic [CH_W-1:0]        cur_ch;
    logic                   busy;

    modport slave (
        input  req_valid, req_addr, req_len, req_rw, drv_done,
        output req_ready, cmp_done, cmp_err, drv_start, drv_ca, drv_len, drv_rw, cur_ch, busy
    );

    modport master (
        output req_valid, req_addr, req_len, req_rw, drv_done,
        input  req_ready, cmp_done, cmp_err, drv_start, drv_ca, drv_len, drv_rw, cur_ch, busy
    );
endinterface

// File: rtl/hyper_ram_txn_scheduler.sv
// hyper_ram_txn_scheduler
// Round-robin front end for the HyperRAM driver. Grants one of N_CH request channels,
// splits the request into bursts limited by MAX_BURST and by row boundaries, packs the
// 48-bit CA word for each burst and runs a start/done handshake with the driver.
// Completion (and timeout abort) is reported per channel with one-cycle pulses.
// Ports:
//   clk_50 : single clock, posedge
//   reset  : synchronous, active-high
//   bus    : hyper_ram_txn_scheduler_if.slave (requests, completions, driver handshake)
module hyper_ram_txn_scheduler #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned ADDR_W    = 23,
    parameter int unsigned LEN_W     = 11,
    parameter int unsigned MAX_BURST = 256,
    parameter int unsigned ROW_WORDS = 512,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic                        clk_50,
    input  logic                        reset,
    hyper_ram_txn_scheduler_if.slave    bus
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              rw_q, rw_d;
    logic [LEN_W-1:0]  drv_len_q, drv_len_d;
    logic [47:0]       drv_ca_q, drv_ca_d;
    logic              drv_rw_q, drv_rw_d;
    logic [N_CH-1:0]   cmp_done_q, cmp_done_d;
    logic [N_CH-1:0]   cmp_err_q, cmp_err_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;

    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   pos;
    logic [N_CH-1:0]   req_ready_c;
    logic [LEN_W-1:0]  grant_len;
    logic [31:0]       row_off;
    logic [31:0]       row_left;
    logic [31:0]       chunk;
    logic [28:0]       ca_field;

    // First valid channel at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            pos = CH_W'((32'(ptr_q) + i) % N_CH);
            if (!grant_found && bus.req_valid[pos]) begin
                grant_found = 1'b1;
                grant_idx   = pos;
            end
        end
    end

    // Burst size: bounded by what is left, the burst limit and the end of the current row.
    always_comb begin
        row_off  = 32'(addr_q) & (ROW_WORDS - 1);
        row_left = ROW_WORDS - row_off;
        chunk    = 32'(rem_q);
        if (32'(MAX_BURST) < chunk) begin
            chunk = 32'(MAX_BURST);
        end
        if (row_left < chunk) begin
            chunk = row_left;
        end
        ca_field = 29'(32'(addr_q) >> 3);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_ch_d    = cur_ch_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        rw_d        = rw_q;
        drv_len_d   = drv_len_q;
        drv_ca_d    = drv_ca_q;
        drv_rw_d    = drv_rw_q;
        tcnt_d      = tcnt_q;
        cmp_done_d  = '0;
        cmp_err_d   = '0;
        req_ready_c = '0;
        grant_len   = bus.req_len[32'(grant_idx)*LEN_W +: LEN_W];

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    addr_d   = bus.req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
                    rem_d    = grant_len;
                    rw_d     = bus.req_rw[grant_idx];
                    cur_ch_d = grant_idx;
                    ptr_d    = CH_W'((32'(grant_idx) + 1) % N_CH);
                    if (grant_len == '0) begin
                        cmp_done_d[grant_idx] = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                drv_len_d = LEN_W'(chunk);
                // {rw, address space, linear burst, row/upper column, reserved, lower column}
                drv_ca_d  = {rw_q, 1'b0, 1'b1, ca_field, 13'b0, addr_q[2:0]};
                drv_rw_d  = rw_q;
                state_d   = StIssue;
            end
            StIssue: begin
                tcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.drv_done) begin
                    rem_d  = rem_q - drv_len_q;
                    addr_d = addr_q + ADDR_W'(drv_len_q);
                    if (rem_q == drv_len_q) begin
                        cmp_done_d[cur_ch_q] = 1'b1;
                        state_d              = StIdle;
                    end else begin
                        state_d = StCalc;
                    end
                end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th waiting cycle: abandon the rest of the request.
                    cmp_done_d[cur_ch_q] = 1'b1;
                    cmp_err_d[cur_ch_q]  = 1'b1;
                    state_d              = StIdle;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cur_ch_q   <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            rw_q       <= 1'b0;
            drv_len_q  <= '0;
            drv_ca_q   <= '0;
            drv_rw_q   <= 1'b0;
            cmp_done_q <= '0;
            cmp_err_q  <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_ch_q   <= cur_ch_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rw_q       <= rw_d;
            drv_len_q  <= drv_len_d;
            drv_ca_q   <= drv_ca_d;
            drv_rw_q   <= drv_rw_d;
            cmp_done_q <= cmp_done_d;
            cmp_err_q  <= cmp_err_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // req_ready is combinational on req_valid; mask it so every output is 0 while in reset.
    assign bus.req_ready = reset ? '0 : req_ready_c;
    assign bus.cmp_done  = cmp_done_q;
    assign bus.cmp_err   = cmp_err_q;
    assign bus.drv_start = (state_q == StIssue);
    assign bus.drv_ca    = drv_ca_q;
    assign bus.drv_len   = drv_len_q;
    assign bus.drv_rw    = drv_rw_q;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
